// File: rtl/alu_flag_ctrl.sv
// Status-flag register, branch-condition evaluator and flag save/restore stack
// sitting on the result side of the 8-bit ALU. Flags are held as {sf, zf, cf, of}.
module alu_flag_ctrl #(
  parameter int STACK_DEPTH = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       alu_valid,
  input  logic [3:0] alu_func,
  input  logic       zf,
  input  logic       of,
  input  logic       cf,
  input  logic       sf,
  input  logic       cond_req,
  input  logic [3:0] cond,
  output logic       cond_valid,
  output logic       cond_true,
  input  logic       flags_push,
  input  logic       flags_pop,
  output logic [3:0] flag_q,
  output logic       stk_empty,
  output logic       stk_full,
  output logic       stk_err
);

  localparam int CW = $clog2(STACK_DEPTH + 1);
  localparam int IW = (STACK_DEPTH > 1) ? $clog2(STACK_DEPTH) : 1;

  // cf=1 means borrow, so unsigned "lower" is cf and signed "less" is sf^of.
  function automatic logic eval_cond(input logic [3:0] c, input logic [3:0] f);
    logic s, z, b, v;
    {s, z, b, v} = f;
    case (c)
      4'd0:    eval_cond = 1'b1;
      4'd1:    eval_cond = z;
      4'd2:    eval_cond = ~z;
      4'd3:    eval_cond = b;
      4'd4:    eval_cond = ~b;
      4'd5:    eval_cond = s;
      4'd6:    eval_cond = ~s;
      4'd7:    eval_cond = v;
      4'd8:    eval_cond = ~v;
      4'd9:    eval_cond = ~b & ~z;
      4'd10:   eval_cond = b | z;
      4'd11:   eval_cond = (s == v);
      4'd12:   eval_cond = (s != v);
      4'd13:   eval_cond = ~z & (s == v);
      4'd14:   eval_cond = z | (s != v);
      default: eval_cond = 1'b0;
    endcase
  endfunction

  logic [3:0]    stack_mem [STACK_DEPTH];
  logic [CW-1:0] cnt;
  logic [CW-1:0] cnt_dec;
  logic [CW-1:0] cnt_nxt;
  logic          capture;
  logic          is_empty;
  logic          is_full;
  logic          push_ok;
  logic          pop_ok;
  logic          req_err;

  // Functions 0, 6 and 8 leave the ALU flag outputs stale.
  always_comb begin
    case (alu_func)
      4'd0, 4'd6, 4'd8: capture = 1'b0;
      default:          capture = alu_valid;
    endcase
  end

  assign is_empty = (cnt == '0);
  assign is_full  = (cnt == CW'(STACK_DEPTH));
  assign cnt_dec  = cnt - CW'(1);
  assign push_ok  = flags_push & ~flags_pop & ~is_full;
  assign pop_ok   = flags_pop & ~flags_push & ~is_empty;
  assign req_err  = (flags_push & flags_pop) | (flags_push & is_full) | (flags_pop & is_empty);

  always_comb begin
    cnt_nxt = cnt;
    if (push_ok)
      cnt_nxt = cnt + CW'(1);
    else if (pop_ok)
      cnt_nxt = cnt_dec;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      flag_q     <= 4'b0000;
      cnt        <= '0;
      stk_empty  <= 1'b1;
      stk_full   <= 1'b0;
      stk_err    <= 1'b0;
      cond_valid <= 1'b0;
      cond_true  <= 1'b0;
    end else begin
      cond_valid <= cond_req;
      if (cond_req)
        cond_true <= eval_cond(cond, flag_q);
      // A legal pop outranks a same-cycle ALU capture.
      if (pop_ok)
        flag_q <= stack_mem[cnt_dec[IW-1:0]];
      else if (capture)
        flag_q <= {sf, zf, cf, of};
      cnt       <= cnt_nxt;
      stk_empty <= (cnt_nxt == '0);
      stk_full  <= (cnt_nxt == CW'(STACK_DEPTH));
      stk_err   <= req_err;
    end
  end

  // Stack contents are data only; a push saves the pre-capture flag_q.
  always_ff @(posedge clk) begin
    if (!rst && push_ok)
      stack_mem[cnt[IW-1:0]] <= flag_q;
  end

endmodule
